// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the CPU data/instruction address path. Accepts one
// access at a time over a valid/ready handshake, checks size/alignment/range,
// performs a big-endian byte/half/word load or store against internal byte
// storage, and returns a single-cycle response READ_LAT edges after acceptance
// (the acceptance edge counts as the first).
//
// Parameters:
//   ADDR_BITS  log2 of storage size in bytes
//   READ_LAT   acceptance-to-response latency, legal range 1..15
//
// Ports:
//   i_clk          system clock, all state on rising edge
//   i_reset        synchronous active-high reset
//   i_req_valid    request present
//   o_req_ready    responder can accept a request this cycle
//   i_req_write    1 = store, 0 = load
//   i_req_size     00 word, 01 half, 10 byte, 11 illegal
//   i_req_addr     byte address
//   i_req_wdata    store data, right-justified
//   o_resp_valid   one-cycle response pulse
//   o_resp_rdata   load data, zero-extended; 0 for stores and errors
//   o_resp_err     misaligned, out-of-range or illegal size
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned READ_LAT  = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err
);

  localparam int unsigned MEM_BYTES = 1 << ADDR_BITS;
  localparam int unsigned CNT_W     = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Control state
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;

  // Latched request
  logic             r_write;
  logic [1:0]       r_size;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  // Registered response
  logic             r_resp_valid;
  logic [31:0]      r_rdata;
  logic             r_err;

  // Byte storage, big-endian within a word; never cleared by reset
  logic [7:0]       r_mem [MEM_BYTES];

  logic             w_accept;
  logic             w_enter_resp;
  logic             w_use_inputs;
  logic             w_write;
  logic [1:0]       w_size;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic             w_err;
  logic [ADDR_BITS-1:0] w_a0;
  logic [ADDR_BITS-1:0] w_a1;
  logic [ADDR_BITS-1:0] w_a2;
  logic [ADDR_BITS-1:0] w_a3;
  logic [31:0]      w_load;

  // Acceptance needs the registered ready so the first post-reset cycle is dead
  assign w_accept = (r_state == ST_IDLE) && r_ready && i_req_valid;

  // With READ_LAT=1 the response state is entered on the acceptance edge itself
  assign w_enter_resp = (READ_LAT == 1) ? w_accept
                                        : ((r_state == ST_WAIT) && (r_cnt <= CNT_W'(1)));

  // On the acceptance edge the latches are not yet loaded, so use the inputs
  assign w_use_inputs = (r_state == ST_IDLE);
  assign w_write = w_use_inputs ? i_req_write : r_write;
  assign w_size  = w_use_inputs ? i_req_size  : r_size;
  assign w_addr  = w_use_inputs ? i_req_addr  : r_addr;
  assign w_wdata = w_use_inputs ? i_req_wdata : r_wdata;

  // Access legality: size, natural alignment, and address within storage
  assign w_err = (w_size == 2'b11)
              || ((w_size == SZ_WORD) && (w_addr[1:0] != 2'b00))
              || ((w_size == SZ_HALF) && w_addr[0])
              || ((w_addr >> ADDR_BITS) != 32'd0);

  // Byte lanes of the access; only meaningful when aligned and in range
  assign w_a0 = w_addr[ADDR_BITS-1:0];
  assign w_a1 = w_a0 + ADDR_BITS'(1);
  assign w_a2 = w_a0 + ADDR_BITS'(2);
  assign w_a3 = w_a0 + ADDR_BITS'(3);

  // Big-endian load data, zero-extended and right-justified
  always_comb begin
    w_load = 32'd0;
    case (w_size)
      SZ_WORD: w_load = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
      SZ_HALF: w_load = {16'd0, r_mem[w_a0], r_mem[w_a1]};
      SZ_BYTE: w_load = {24'd0, r_mem[w_a0]};
      default: w_load = 32'd0;
    endcase
  end

  // FSM, request latch, response registers and storage writes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'd0;
      r_err        <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_write <= i_req_write;
            r_size  <= i_req_size;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_cnt   <= CNT_LOAD;
            r_ready <= 1'b0;
            r_state <= (READ_LAT == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_ready <= 1'b0;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (w_enter_resp) begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase

      // Load data is sampled and stores commit on the RESP-entry edge
      if (w_enter_resp) begin
        r_resp_valid <= 1'b1;
        r_err        <= w_err;
        r_rdata      <= (w_err || w_write) ? 32'd0 : w_load;
        if (w_write && !w_err) begin
          case (w_size)
            SZ_WORD: begin
              r_mem[w_a0] <= w_wdata[31:24];
              r_mem[w_a1] <= w_wdata[23:16];
              r_mem[w_a2] <= w_wdata[15:8];
              r_mem[w_a3] <= w_wdata[7:0];
            end
            SZ_HALF: begin
              r_mem[w_a0] <= w_wdata[15:8];
              r_mem[w_a1] <= w_wdata[7:0];
            end
            SZ_BYTE: begin
              r_mem[w_a0] <= w_wdata[7:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign o_req_ready  = r_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder: expected responses are pushed to a
// queue as each request is driven and popped when the response pulse appears.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int unsigned LAT = 2;

  typedef struct packed {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic        ee;
    logic [31:0] er;
  } req_t;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [1:0]  i_req_size;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [32:0] exp_q [$];

  mem_responder #(.ADDR_BITS(8), .READ_LAT(LAT)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_write  (i_req_write),
    .i_req_size   (i_req_size),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_resp_valid (o_resp_valid),
    .o_resp_rdata (o_resp_rdata),
    .o_resp_err   (o_resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic req_t mk(input logic w, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] d, input logic ee, input logic [31:0] er);
    req_t r;
    r.w = w; r.sz = sz; r.a = a; r.d = d; r.ee = ee; r.er = er;
    return r;
  endfunction

  task automatic drive(input req_t r);
    i_req_write = r.w;
    i_req_size  = r.sz;
    i_req_addr  = r.a;
    i_req_wdata = r.d;
  endtask

  // Drives one request, pushes its expectation, and reports what the DUT returned
  task automatic do_req(input req_t r, output logic got, output int lat,
                        output logic [31:0] rd, output logic er,
                        output logic [31:0] hold, output logic still_hi);
    int n;
    got = 1'b0; lat = 0; rd = 32'd0; er = 1'b0; hold = 32'd0; still_hi = 1'b0;
    exp_q.push_back({r.ee, r.er});
    n = 0;
    while (o_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (o_req_ready !== 1'b1) return;
    drive(r);
    i_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    n = 1;
    while (o_resp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (o_resp_valid !== 1'b1) return;
    got = 1'b1;
    lat = n;
    rd  = o_resp_rdata;
    er  = o_resp_err;
    @(negedge clk);
    hold     = o_resp_rdata;
    still_hi = o_resp_valid;
  endtask

  task automatic test_reset;
    int idle_bad;
    i_reset = 1'b1;
    i_req_valid = 1'b0;
    drive(mk(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 32'd0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (o_req_ready !== 1'b0 || o_resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: ready=%b resp_valid=%b want 0/0", o_req_ready, o_resp_valid);
    end
    total++;
    if (o_resp_rdata !== 32'd0 || o_resp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_data: rdata=%h err=%b want 0/0", o_resp_rdata, o_resp_err);
    end
    i_reset = 1'b0;
    @(negedge clk);
    total++;
    if (o_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after: ready=%b want 1", o_req_ready);
    end
    idle_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) idle_bad++;
    end
    total++;
    if (idle_bad != 0) begin
      bad++;
      $display("FAIL idle_quiet: bad_cycles=%0d want 0", idle_bad);
    end
  endtask

  task automatic test_word;
    req_t t [2];
    logic got, er, hi; int lat; logic [31:0] rd, hold; logic [32:0] e;
    t[0] = mk(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    t[1] = mk(1'b0, 2'b00, 32'h10, 32'h0,       1'b0, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) begin
      do_req(t[i], got, lat, rd, er, hold, hi);
      e = exp_q.pop_front();
      total++;
      if (!got || lat != int'(LAT)) begin
        bad++; $display("FAIL word[%0d]_latency: got=%b lat=%0d want %0d", i, got, lat, LAT);
      end
      total++;
      if ({er, rd} !== e) begin
        bad++; $display("FAIL word[%0d]_resp: err=%b rdata=%h want err=%b rdata=%h", i, er, rd, e[32], e[31:0]);
      end
      total++;
      if (hi !== 1'b0 || hold !== e[31:0]) begin
        bad++; $display("FAIL word[%0d]_pulse_hold: valid=%b rdata=%h want 0/%h", i, hi, hold, e[31:0]);
      end
    end
  endtask

  task automatic test_byte_half;
    req_t t [4];
    logic got, er, hi; int lat; logic [31:0] rd, hold; logic [32:0] e;
    t[0] = mk(1'b1, 2'b10, 32'h12, 32'h55, 1'b0, 32'h0);
    t[1] = mk(1'b0, 2'b00, 32'h10, 32'h0,  1'b0, 32'hDEAD55EF);
    t[2] = mk(1'b0, 2'b01, 32'h12, 32'h0,  1'b0, 32'h000055EF);
    t[3] = mk(1'b0, 2'b10, 32'h13, 32'h0,  1'b0, 32'h000000EF);
    for (int i = 0; i < 4; i++) begin
      do_req(t[i], got, lat, rd, er, hold, hi);
      e = exp_q.pop_front();
      total++;
      if (!got || lat != int'(LAT)) begin
        bad++; $display("FAIL subword[%0d]_latency: got=%b lat=%0d want %0d", i, got, lat, LAT);
      end
      total++;
      if ({er, rd} !== e) begin
        bad++; $display("FAIL subword[%0d]_resp: err=%b rdata=%h want err=%b rdata=%h", i, er, rd, e[32], e[31:0]);
      end
      total++;
      if (hi !== 1'b0 || hold !== e[31:0]) begin
        bad++; $display("FAIL subword[%0d]_pulse_hold: valid=%b rdata=%h want 0/%h", i, hi, hold, e[31:0]);
      end
    end
  endtask

  task automatic test_errors;
    req_t t [5];
    logic got, er, hi; int lat; logic [31:0] rd, hold; logic [32:0] e;
    t[0] = mk(1'b0, 2'b00, 32'h11,  32'h0,      1'b1, 32'h0);
    t[1] = mk(1'b1, 2'b01, 32'h13,  32'hFFFF,   1'b1, 32'h0);
    t[2] = mk(1'b1, 2'b11, 32'h10,  32'h0BAD0BAD, 1'b1, 32'h0);
    t[3] = mk(1'b0, 2'b00, 32'h100, 32'h0,      1'b1, 32'h0);
    t[4] = mk(1'b0, 2'b00, 32'h10,  32'h0,      1'b0, 32'hDEAD55EF);
    for (int i = 0; i < 5; i++) begin
      do_req(t[i], got, lat, rd, er, hold, hi);
      e = exp_q.pop_front();
      total++;
      if (!got || lat != int'(LAT)) begin
        bad++; $display("FAIL err[%0d]_latency: got=%b lat=%0d want %0d", i, got, lat, LAT);
      end
      total++;
      if ({er, rd} !== e) begin
        bad++; $display("FAIL err[%0d]_resp: err=%b rdata=%h want err=%b rdata=%h", i, er, rd, e[32], e[31:0]);
      end
      total++;
      if (hi !== 1'b0 || hold !== e[31:0]) begin
        bad++; $display("FAIL err[%0d]_pulse_hold: valid=%b rdata=%h want 0/%h", i, hi, hold, e[31:0]);
      end
    end
  endtask

  // req_valid stays high; each new request is presented right after acceptance
  task automatic test_back_to_back;
    req_t t [4];
    int acc [4];
    int n, m, busy_bad;
    logic [32:0] e;
    t[0] = mk(1'b1, 2'b00, 32'h40, 32'hA1B2C3D4, 1'b0, 32'h0);
    t[1] = mk(1'b0, 2'b00, 32'h40, 32'h0,        1'b0, 32'hA1B2C3D4);
    t[2] = mk(1'b1, 2'b10, 32'h43, 32'h99,       1'b0, 32'h0);
    t[3] = mk(1'b0, 2'b01, 32'h42, 32'h0,        1'b0, 32'h0000C399);
    busy_bad = 0;
    drive(t[0]);
    exp_q.push_back({t[0].ee, t[0].er});
    i_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (o_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      total++;
      if (o_req_ready !== 1'b1) begin
        bad++; $display("FAIL b2b[%0d]_ready: ready=%b want 1", k, o_req_ready);
        void'(exp_q.pop_front());
        break;
      end
      acc[k] = cyc;
      @(posedge clk);
      @(negedge clk);
      if (k < 3) begin
        drive(t[k+1]);
        exp_q.push_back({t[k+1].ee, t[k+1].er});
      end else begin
        i_req_valid = 1'b0;
      end
      m = 1;
      while (o_resp_valid !== 1'b1 && m < 40) begin
        if (o_req_ready !== 1'b0) busy_bad++;
        @(negedge clk);
        m++;
      end
      if (o_req_ready !== 1'b0) busy_bad++;
      e = exp_q.pop_front();
      total++;
      if (o_resp_valid !== 1'b1 || m != int'(LAT) || {o_resp_err, o_resp_rdata} !== e) begin
        bad++;
        $display("FAIL b2b[%0d]_resp: valid=%b lat=%0d err=%b rdata=%h want 1/%0d/%b/%h",
                 k, o_resp_valid, m, o_resp_err, o_resp_rdata, LAT, e[32], e[31:0]);
      end
      @(negedge clk);
      if (k > 0) begin
        total++;
        if (acc[k] - acc[k-1] != int'(LAT) + 1) begin
          bad++; $display("FAIL b2b[%0d]_period: cycles=%0d want %0d", k, acc[k] - acc[k-1], LAT + 1);
        end
      end
    end
    i_req_valid = 1'b0;
    total++;
    if (busy_bad != 0) begin
      bad++; $display("FAIL b2b_ready_busy: ready high in %0d busy cycles, want 0", busy_bad);
    end
  endtask

  // Reset in WAIT abandons the store before it commits
  task automatic test_reset_mid;
    logic got, er, hi; int lat; logic [31:0] rd, hold; logic [32:0] e;
    int n, spur;
    do_req(mk(1'b1, 2'b00, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0), got, lat, rd, er, hold, hi);
    e = exp_q.pop_front();
    total++;
    if (!got || {er, rd} !== e) begin
      bad++; $display("FAIL rmid_prestore: got=%b err=%b rdata=%h want 1/%b/%h", got, er, rd, e[32], e[31:0]);
    end
    n = 0;
    while (o_req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    drive(mk(1'b1, 2'b00, 32'h20, 32'h12345678, 1'b0, 32'h0));
    i_req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    total++;
    if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b0 || o_resp_rdata !== 32'd0) begin
      bad++;
      $display("FAIL rmid_after_reset: valid=%b ready=%b rdata=%h want 0/0/0", o_resp_valid, o_req_ready, o_resp_rdata);
    end
    spur = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_resp_valid !== 1'b0) spur++;
    end
    total++;
    if (spur != 0) begin
      bad++; $display("FAIL rmid_no_resp: pulses=%0d want 0", spur);
    end
    do_req(mk(1'b0, 2'b00, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D), got, lat, rd, er, hold, hi);
    e = exp_q.pop_front();
    total++;
    if (!got || lat != int'(LAT) || {er, rd} !== e) begin
      bad++;
      $display("FAIL rmid_reload: got=%b lat=%0d err=%b rdata=%h want 1/%0d/%b/%h", got, lat, er, rd, LAT, e[32], e[31:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
